// File: rtl/score_board_reader.sv
// score_board_reader: read-side sweep of the score RAM.
// On a display request it reads the 8 per-player entries and the global-best
// entry, then reports the requested player's best, the global best, the
// leading player ID, and whether the leader's score matches the global best.
// The RAM port is released immediately whenever the writer raises bus_busy.
// Optional macro SCORE_BCD_EN adds pb_bcd, a registered BCD form of personal_best.
module score_board_reader #(
  parameter int         NUM_PLAYERS = 8,
  parameter logic [4:0] GLOBAL_ADDR = 5'd8,
  parameter int         SCORE_W     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_req,
  input  logic [2:0]         disp_id,
  input  logic               bus_busy,
  input  logic [SCORE_W-1:0] RAM_data,
  output logic [4:0]         RAM_addr,
  output logic               RAM_R,
  output logic [SCORE_W-1:0] personal_best,
  output logic [SCORE_W-1:0] global_best,
  output logic [2:0]         leader_id,
  output logic               mismatch,
  output logic               busy,
  output logic               valid
`ifdef SCORE_BCD_EN
  ,
  output logic [9:0]         pb_bcd
`endif
);

  localparam logic [4:0] LAST_PLAYER = 5'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {IDLE, WAIT_BUS, SCAN, DRAIN, DONE} state_t;

  state_t             state_r;
  logic [4:0]         ram_addr_r;
  logic               ram_r_r;
  logic               cap_vld_r;   // an address was driven in the previous cycle
  logic [4:0]         cap_idx_r;   // which address that was
  logic [SCORE_W-1:0] max_r;
  logic [2:0]         lead_r;
  logic [SCORE_W-1:0] pb_r;
  logic [2:0]         id_r;

`ifdef SCORE_BCD_EN
  // Shift-and-add-3 binary to BCD: {hundreds[1:0], tens[3:0], units[3:0]}.
  function automatic logic [9:0] to_bcd(input logic [SCORE_W-1:0] v);
    logic [SCORE_W+9:0] sh;
    sh = '0;
    sh[SCORE_W-1:0] = v;
    for (int i = 0; i < SCORE_W; i++) begin
      if (sh[SCORE_W+3:SCORE_W] >= 4'd5)   sh[SCORE_W+3:SCORE_W]   = sh[SCORE_W+3:SCORE_W] + 4'd3;
      if (sh[SCORE_W+7:SCORE_W+4] >= 4'd5) sh[SCORE_W+7:SCORE_W+4] = sh[SCORE_W+7:SCORE_W+4] + 4'd3;
      sh = sh << 1;
    end
    return sh[SCORE_W+9:SCORE_W];
  endfunction
`endif

  assign RAM_addr = ram_addr_r;
  // The writer owns the port the moment bus_busy rises, so the strobe is gated combinationally.
  assign RAM_R    = ram_r_r & ~bus_busy;

  // Scan FSM, capture pipeline and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ram_addr_r    <= 5'd0;
      ram_r_r       <= 1'b0;
      cap_vld_r     <= 1'b0;
      cap_idx_r     <= 5'd0;
      max_r         <= '0;
      lead_r        <= 3'd0;
      pb_r          <= '0;
      id_r          <= 3'd0;
      personal_best <= '0;
      global_best   <= '0;
      leader_id     <= 3'd0;
      mismatch      <= 1'b0;
      busy          <= 1'b0;
      valid         <= 1'b0;
`ifdef SCORE_BCD_EN
      pb_bcd        <= 10'd0;
`endif
    end else begin
      valid     <= 1'b0;
      cap_vld_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (disp_req) begin
            id_r   <= disp_id;
            busy   <= 1'b1;
            max_r  <= '0;
            lead_r <= 3'd0;
            pb_r   <= '0;
            if (!bus_busy) begin
              state_r    <= SCAN;
              ram_addr_r <= 5'd0;
              ram_r_r    <= 1'b1;
            end else begin
              state_r <= WAIT_BUS;
            end
          end
        end
        WAIT_BUS: begin
          if (!bus_busy) begin
            state_r    <= SCAN;
            ram_addr_r <= 5'd0;
            ram_r_r    <= 1'b1;
            max_r      <= '0;
            lead_r     <= 3'd0;
            pb_r       <= '0;
          end
        end
        SCAN, DRAIN: begin
          if (bus_busy) begin
            // Abort: drop everything gathered so far and rescan from 0 later.
            state_r <= WAIT_BUS;
            ram_r_r <= 1'b0;
            max_r   <= '0;
            lead_r  <= 3'd0;
            pb_r    <= '0;
          end else begin
            cap_vld_r <= ram_r_r;
            cap_idx_r <= ram_addr_r;
            // Player entry capture; strictly-greater keeps the lower ID on ties.
            if (cap_vld_r && (cap_idx_r <= LAST_PLAYER)) begin
              if (RAM_data > max_r) begin
                max_r  <= RAM_data;
                lead_r <= cap_idx_r[2:0];
              end
              if (cap_idx_r == {2'b00, id_r}) pb_r <= RAM_data;
            end
            if (state_r == SCAN) begin
              if (ram_addr_r == LAST_PLAYER) begin
                ram_addr_r <= GLOBAL_ADDR;
              end else if (ram_addr_r == GLOBAL_ADDR) begin
                ram_r_r <= 1'b0;
                state_r <= DRAIN;
              end else begin
                ram_addr_r <= ram_addr_r + 5'd1;
              end
            end else if (cap_vld_r && (cap_idx_r == GLOBAL_ADDR)) begin
              global_best   <= RAM_data;
              personal_best <= pb_r;
              leader_id     <= lead_r;
              mismatch      <= (max_r != RAM_data);
              valid         <= 1'b1;
              busy          <= 1'b0;
              state_r       <= DONE;
`ifdef SCORE_BCD_EN
              pb_bcd        <= to_bcd(pb_r);
`endif
            end else begin
              state_r <= DRAIN;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ram_r_r <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_board_reader.sv
// Directed, table-driven bench for score_board_reader with a one-cycle-latency RAM model.
module tb_score_board_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_req;
  logic [2:0] disp_id;
  logic       bus_busy;
  logic [6:0] RAM_data;
  logic [4:0] RAM_addr;
  logic       RAM_R;
  logic [6:0] personal_best;
  logic [6:0] global_best;
  logic [2:0] leader_id;
  logic       mismatch;
  logic       busy;
  logic       valid;
`ifdef SCORE_BCD_EN
  logic [9:0] pb_bcd;
`endif

  int checks   = 0;
  int failures = 0;

  logic [8:0][6:0] ram_m;

  typedef struct {
    logic [8:0][6:0] mem;
    logic [2:0]      id;
    logic [6:0]      pb;
    logic [6:0]      gb;
    logic [2:0]      lead;
    logic            mm;
    logic [9:0]      bcd;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  score_board_reader dut (
    .clk(clk), .rst(rst), .disp_req(disp_req), .disp_id(disp_id),
    .bus_busy(bus_busy), .RAM_data(RAM_data), .RAM_addr(RAM_addr), .RAM_R(RAM_R),
    .personal_best(personal_best), .global_best(global_best), .leader_id(leader_id),
    .mismatch(mismatch), .busy(busy), .valid(valid)
`ifdef SCORE_BCD_EN
    , .pb_bcd(pb_bcd)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: data for the strobed address appears after the edge.
  always @(posedge clk) begin
    if (RAM_R && RAM_addr <= 5'd8) RAM_data <= ram_m[RAM_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue a request and verify the result at edge 10 and the single-cycle valid pulse.
  task automatic do_scan(input int v);
    logic early;
    ram_m = vecs[v].mem;
    @(negedge clk);
    disp_req = 1'b1;
    disp_id  = vecs[v].id;
    @(posedge clk); #1;
    disp_req = 1'b0;
    chk("busy_start", {31'd0, busy}, 32'd1);
    early = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      if (valid) early = 1'b1;
    end
    chk("valid_early", {31'd0, early}, 32'd0);
    @(posedge clk); #1;
    chk("valid_edge10", {31'd0, valid}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("personal_best", {25'd0, personal_best}, {25'd0, vecs[v].pb});
    chk("global_best", {25'd0, global_best}, {25'd0, vecs[v].gb});
    chk("leader_id", {29'd0, leader_id}, {29'd0, vecs[v].lead});
    chk("mismatch", {31'd0, mismatch}, {31'd0, vecs[v].mm});
`ifdef SCORE_BCD_EN
    chk("pb_bcd", {22'd0, pb_bcd}, {22'd0, vecs[v].bcd});
`endif
    @(posedge clk); #1;
    chk("valid_pulse", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < NV; i++) begin
      vecs[i].mem = '0;
    end
    vecs[0].mem[5] = 7'd9;  vecs[0].mem[1] = 7'd8; vecs[0].mem[8] = 7'd9;
    vecs[0].id = 3'd5; vecs[0].pb = 7'd9;  vecs[0].gb = 7'd9;  vecs[0].lead = 3'd5; vecs[0].mm = 1'b0; vecs[0].bcd = 10'h009;
    vecs[1].mem[5] = 7'd9;  vecs[1].mem[1] = 7'd8; vecs[1].mem[8] = 7'd7;
    vecs[1].id = 3'd1; vecs[1].pb = 7'd8;  vecs[1].gb = 7'd7;  vecs[1].lead = 3'd5; vecs[1].mm = 1'b1; vecs[1].bcd = 10'h008;
    vecs[2].mem[2] = 7'd12; vecs[2].mem[6] = 7'd12; vecs[2].mem[8] = 7'd12;
    vecs[2].id = 3'd6; vecs[2].pb = 7'd12; vecs[2].gb = 7'd12; vecs[2].lead = 3'd2; vecs[2].mm = 1'b0; vecs[2].bcd = 10'h012;
    vecs[3].id = 3'd3; vecs[3].pb = 7'd0;  vecs[3].gb = 7'd0;  vecs[3].lead = 3'd0; vecs[3].mm = 1'b0; vecs[3].bcd = 10'h000;
    vecs[4].mem[7] = 7'd127; vecs[4].mem[0] = 7'd100; vecs[4].mem[8] = 7'd127;
    vecs[4].id = 3'd7; vecs[4].pb = 7'd127; vecs[4].gb = 7'd127; vecs[4].lead = 3'd7; vecs[4].mm = 1'b0; vecs[4].bcd = 10'h127;
    vecs[5].mem[0] = 7'd50; vecs[5].mem[8] = 7'd3;
    vecs[5].id = 3'd0; vecs[5].pb = 7'd50; vecs[5].gb = 7'd3;  vecs[5].lead = 3'd0; vecs[5].mm = 1'b1; vecs[5].bcd = 10'h050;
    vecs[6].mem[4] = 7'd107; vecs[6].mem[8] = 7'd107;
    vecs[6].id = 3'd4; vecs[6].pb = 7'd107; vecs[6].gb = 7'd107; vecs[6].lead = 3'd4; vecs[6].mm = 1'b0; vecs[6].bcd = 10'h107;

    rst = 1'b1; disp_req = 1'b0; disp_id = 3'd0; bus_busy = 1'b0; ram_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("reset_outputs",
          {6'd0, RAM_R, RAM_addr, personal_best, global_best, leader_id, mismatch, busy, valid}, 32'd0);
    end

    for (int v = 0; v < NV; v++) do_scan(v);

    // Bus contention: writer takes the port after edge 4 for three edges.
    ram_m = vecs[0].mem;
    @(negedge clk); disp_req = 1'b1; disp_id = 3'd5;
    @(posedge clk); #1; disp_req = 1'b0;
    for (int e = 1; e <= 4; e++) begin @(posedge clk); #1; end
    bus_busy = 1'b1;
    #1;
    chk("abort_ram_r", {31'd0, RAM_R}, 32'd0);
    seen = 1'b0;
    for (int e = 5; e <= 7; e++) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
    bus_busy = 1'b0;
    chk("abort_hold_pb", {25'd0, personal_best}, 32'd107);
    chk("abort_hold_lead", {29'd0, leader_id}, 32'd4);
    for (int e = 8; e <= 17; e++) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    chk("rescan_valid", {31'd0, valid}, 32'd1);
    chk("rescan_pb", {25'd0, personal_best}, 32'd9);
    chk("rescan_gb", {25'd0, global_best}, 32'd9);
    chk("rescan_lead", {29'd0, leader_id}, 32'd5);
    chk("rescan_mm", {31'd0, mismatch}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a scan.
    ram_m = vecs[1].mem;
    @(negedge clk); disp_req = 1'b1; disp_id = 3'd1;
    @(posedge clk); #1; disp_req = 1'b0;
    for (int e = 1; e <= 6; e++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midreset_outputs",
        {6'd0, RAM_R, RAM_addr, personal_best, global_best, leader_id, mismatch, busy, valid}, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
    chk("midreset_no_valid", {31'd0, seen}, 32'd0);
    do_scan(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_board_reader.md
Name: score_board_reader

Overview:
- Read-side companion to the score-tracking writer.
- On a display request, sweeps the score RAM (8 per-player best entries plus one global-best entry) with synchronous reads.
- Reports the requested player's best, the global best and the leading player ID, plus a consistency flag.
- Sits between the score RAM port and the display/LCD logic.
- Yields the RAM port to the writer whenever the writer is active.

Parameters:
- NUM_PLAYERS, 8, number of per-player entries, stored at RAM addresses 0..NUM_PLAYERS-1.
- GLOBAL_ADDR, 5'd8, RAM address of the global-best entry.
- SCORE_W, 7, score width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- disp_req  input  1  read request; sampled only in IDLE.
- disp_id  input  3  player ID to report; latched when the request is accepted.
- bus_busy  input  1  writer owns the RAM port; the reader must not drive a read.
- RAM_data  input  SCORE_W  RAM read data; one-cycle synchronous read latency.
- RAM_addr  output  5  RAM address.
- RAM_R  output  1  read strobe, high while a scan address is driven.
- personal_best  output  SCORE_W  best score of the latched disp_id.
- global_best  output  SCORE_W  value read from GLOBAL_ADDR.
- leader_id  output  3  ID holding the highest per-player score.
- mismatch  output  1  leader's score differs from global_best.
- busy  output  1  scan in progress.
- valid  output  1  one-cycle pulse when all results are updated.

Behaviour:
- Reset values: every output 0; FSM in IDLE; internal max register 0.
- States: IDLE, WAIT_BUS, SCAN, DRAIN, DONE.
- IDLE:
  - disp_req=1 latches disp_id.
  - If bus_busy=0, go to SCAN with idx=0. Otherwise go to WAIT_BUS.
  - disp_req is ignored in every other state; no queuing.
- WAIT_BUS: move to SCAN with idx=0 on the first edge where bus_busy=0.
- SCAN:
  - Drive RAM_addr=idx and RAM_R=1; idx increments each cycle.
  - Sequence is 0..NUM_PLAYERS-1, then GLOBAL_ADDR.
  - After GLOBAL_ADDR is driven, go to DRAIN.
- Capture rule: data for the address driven in cycle k is registered at the edge ending cycle k+1.
- Pipeline: address k is driven after edge k, where the accept edge is edge 0. Its data is captured at edge k+2.
- Leader: running max over player entries. Update only on strictly greater, so ties keep the lower ID.
  - Example: all-zero RAM gives leader_id=0.
- personal_best: captured when the captured index equals the latched disp_id.
- global_best: captured from GLOBAL_ADDR data.
- DRAIN/DONE:
  - GLOBAL_ADDR data is captured at edge 10.
  - At that edge, valid=1 and busy=0; mismatch = (max != global_best).
  - valid is high for exactly one cycle, then the FSM returns to IDLE.
- Latency: valid rises at edge 10 after the accept edge when bus_busy stays low. busy is high from edge 0 through edge 9.
- Bus contention: bus_busy=1 during SCAN or DRAIN aborts the scan.
  - Same cycle: RAM_R=0; max and partial captures are discarded.
  - Go to WAIT_BUS, then restart from idx 0.
  - Output registers keep their previous values until a full scan completes. valid never pulses for an aborted scan.
- RAM_addr holds its last value when RAM_R=0.
- Widths: compare SCORE_W-bit unsigned values; no arithmetic overflow is possible.
- disp_id values >= NUM_PLAYERS: personal_best reported as 0.
- Reset mid-scan: immediate return to reset values. No valid pulse for the interrupted scan.

Optional Feature:
- Macro: SCORE_BCD_EN.
- Defined:
  - Adds outputs pb_bcd[9:0], holding the hundreds digit (2 bits), tens (4) and units (4) of personal_best.
  - Registered and updated on the same edge as valid.
  - Conversion is combinational divide-free double-dabble on the captured value, with no extra latency.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset hold, then release: all outputs 0 and RAM_R=0 for 5 cycles with disp_req=0.
- Preload RAM[5]=9, RAM[1]=8, RAM[8]=9, others 0; disp_req with disp_id=5 → valid at edge 10, personal_best=9, leader_id=5, global_best=9, mismatch=0.
- Same RAM with RAM[8]=7; disp_id=1 → personal_best=8, leader_id=5, global_best=7, mismatch=1.
- Tie case RAM[2]=RAM[6]=12 → leader_id=2.
- bus_busy pulsed high at edge 4 for 3 cycles → RAM_R drops the same cycle and no valid pulse; the rescan completes with correct values, valid 10 edges after bus_busy falls.
- rst asserted at edge 6 of a scan → outputs immediately 0, no valid; a following request completes normally.
- With SCORE_BCD_EN, personal_best=107 → pb_bcd=1,0,7.
